// File: rtl/alu_unit_if.sv
// Opcode/ROB tag types plus the RS-issue and CDB bundle seen by the ALU.
// Master side is the RS/arbiter/ROB; slave side is alu_unit.
package alu_unit_pkg;
  typedef enum logic [5:0] {
    OPENUM_NOP, OPENUM_LUI, OPENUM_AUIPC, OPENUM_JAL, OPENUM_JALR,
    OPENUM_BEQ, OPENUM_BNE, OPENUM_BLT, OPENUM_BGE, OPENUM_BLTU, OPENUM_BGEU,
    OPENUM_LB, OPENUM_LW, OPENUM_SB, OPENUM_SW,
    OPENUM_ADDI, OPENUM_SLTI, OPENUM_SLTIU, OPENUM_XORI, OPENUM_ORI, OPENUM_ANDI,
    OPENUM_SLLI, OPENUM_SRLI, OPENUM_SRAI,
    OPENUM_ADD, OPENUM_SUB, OPENUM_SLL, OPENUM_SLT, OPENUM_SLTU,
    OPENUM_XOR, OPENUM_SRL, OPENUM_SRA, OPENUM_OR, OPENUM_AND
  } OPENUM_TYPE;

  typedef logic [3:0] ROB_POS_TYPE;
  localparam ROB_POS_TYPE ZERO_ROB = 4'd0;
endpackage

interface alu_unit_if;
  import alu_unit_pkg::*;

  OPENUM_TYPE  in_rs_op;
  logic [31:0] in_rs_value1;
  logic [31:0] in_rs_value2;
  logic [31:0] in_rs_imm;
  ROB_POS_TYPE in_rs_rob_pos;
  logic [31:0] in_rs_pc;
  logic        out_rs_stall;
  logic        in_rob_xbp;
  logic        in_cdb_grant;
  ROB_POS_TYPE out_cdb_rob_pos;
  logic [31:0] out_cdb_value;
  logic        out_cdb_jump;
  logic [31:0] out_cdb_target;
  logic        out_err_overflow;

  modport master (
    output in_rs_op, in_rs_value1, in_rs_value2, in_rs_imm, in_rs_rob_pos, in_rs_pc,
    output in_rob_xbp, in_cdb_grant,
    input  out_rs_stall, out_cdb_rob_pos, out_cdb_value, out_cdb_jump, out_cdb_target,
    input  out_err_overflow
  );

  modport slave (
    input  in_rs_op, in_rs_value1, in_rs_value2, in_rs_imm, in_rs_rob_pos, in_rs_pc,
    input  in_rob_xbp, in_cdb_grant,
    output out_rs_stall, out_cdb_rob_pos, out_cdb_value, out_cdb_jump, out_cdb_target,
    output out_err_overflow
  );
endinterface

// File: rtl/alu_unit.sv
// RV32I ALU/branch unit: issue is computed and pushed next edge, CDB driven combinationally from FIFO head.
// Registered out_rs_stall keeps STALL_MARGIN free entries; ALU_STATS_EN adds exec/taken counters.
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STALL_MARGIN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  alu_unit_if.slave   bus
`ifdef ALU_STATS_EN
  ,
  output logic [31:0] out_stat_exec,
  output logic [31:0] out_stat_taken
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    ROB_POS_TYPE rob_pos;
    logic [31:0] value;
    logic        jump;
    logic [31:0] target;
  } res_t;

  res_t          mem [FIFO_DEPTH];
  res_t          res;
  res_t          head;
  logic [31:0]   op2;
  logic [4:0]    shamt;
  logic          taken;
  logic          is_branch;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          stall_q, stall_d, err_q, err_d;
  logic          push, pop, full;

  always_comb begin
    op2 = (bus.in_rs_op inside {OPENUM_ADDI, OPENUM_SLTI, OPENUM_SLTIU, OPENUM_XORI,
                                OPENUM_ORI, OPENUM_ANDI, OPENUM_SLLI, OPENUM_SRLI,
                                OPENUM_SRAI}) ? bus.in_rs_imm : bus.in_rs_value2;
    shamt       = op2[4:0];
    res         = '0;
    res.rob_pos = bus.in_rs_rob_pos;
    res.target  = bus.in_rs_pc + 32'd4;
    taken       = 1'b0;
    is_branch   = 1'b0;
    case (bus.in_rs_op)
      OPENUM_ADD, OPENUM_ADDI:   res.value = bus.in_rs_value1 + op2;
      OPENUM_SUB:                res.value = bus.in_rs_value1 - op2;
      OPENUM_SLL, OPENUM_SLLI:   res.value = bus.in_rs_value1 << shamt;
      OPENUM_SRL, OPENUM_SRLI:   res.value = bus.in_rs_value1 >> shamt;
      OPENUM_SRA, OPENUM_SRAI:   res.value = 32'($signed(bus.in_rs_value1) >>> shamt);
      OPENUM_SLT, OPENUM_SLTI:   res.value = {31'b0, $signed(bus.in_rs_value1) < $signed(op2)};
      OPENUM_SLTU, OPENUM_SLTIU: res.value = {31'b0, bus.in_rs_value1 < op2};
      OPENUM_XOR, OPENUM_XORI:   res.value = bus.in_rs_value1 ^ op2;
      OPENUM_OR, OPENUM_ORI:     res.value = bus.in_rs_value1 | op2;
      OPENUM_AND, OPENUM_ANDI:   res.value = bus.in_rs_value1 & op2;
      OPENUM_LUI:                res.value = bus.in_rs_imm;
      OPENUM_AUIPC:              res.value = bus.in_rs_pc + bus.in_rs_imm;
      OPENUM_JAL: begin
        res.value  = bus.in_rs_pc + 32'd4;
        res.target = bus.in_rs_pc + bus.in_rs_imm;
        res.jump   = 1'b1;
      end
      OPENUM_JALR: begin
        res.value  = bus.in_rs_pc + 32'd4;
        res.target = (bus.in_rs_value1 + bus.in_rs_imm) & ~32'd1;
        res.jump   = 1'b1;
      end
      OPENUM_BEQ:  begin is_branch = 1'b1; taken = bus.in_rs_value1 == op2; end
      OPENUM_BNE:  begin is_branch = 1'b1; taken = bus.in_rs_value1 != op2; end
      OPENUM_BLT:  begin is_branch = 1'b1; taken = $signed(bus.in_rs_value1) <  $signed(op2); end
      OPENUM_BGE:  begin is_branch = 1'b1; taken = $signed(bus.in_rs_value1) >= $signed(op2); end
      OPENUM_BLTU: begin is_branch = 1'b1; taken = bus.in_rs_value1 <  op2; end
      OPENUM_BGEU: begin is_branch = 1'b1; taken = bus.in_rs_value1 >= op2; end
      default: ;
    endcase
    if (is_branch && taken) begin
      res.jump   = 1'b1;
      res.target = bus.in_rs_pc + bus.in_rs_imm;
    end
  end

  // Flush wins over push and pop; a full FIFO still accepts a push when the head pops.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q;
    push    = 1'b0;
    pop     = 1'b0;
    full    = count_q == CW'(FIFO_DEPTH);
    if (rdy) begin
      if (bus.in_rob_xbp) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        pop = (count_q != '0) && bus.in_cdb_grant;
        if (bus.in_rs_op != OPENUM_NOP) begin
          if (!full || pop) push = 1'b1;
          else              err_d = 1'b1;
        end
        if (push) tail_d = tail_q + 1'b1;
        if (pop)  head_d = head_q + 1'b1;
        count_d = count_q + CW'(push) - CW'(pop);
      end
    end
    stall_d = count_d >= CW'(FIFO_DEPTH - STALL_MARGIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (rdy) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail_q] <= res;
  end

  assign head                 = mem[head_q];
  assign bus.out_cdb_rob_pos  = (count_q != '0) ? head.rob_pos : ZERO_ROB;
  assign bus.out_cdb_value    = (count_q != '0) ? head.value   : 32'd0;
  assign bus.out_cdb_jump     = (count_q != '0) && head.jump;
  assign bus.out_cdb_target   = (count_q != '0) ? head.target  : 32'd0;
  assign bus.out_rs_stall     = stall_q;
  assign bus.out_err_overflow = err_q;

`ifdef ALU_STATS_EN
  logic [31:0] stat_exec_q, stat_taken_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_exec_q  <= '0;
      stat_taken_q <= '0;
    end else if (push) begin
      stat_exec_q  <= stat_exec_q + 32'd1;
      stat_taken_q <= stat_taken_q + {31'b0, res.jump};
    end
  end

  assign out_stat_exec  = stat_exec_q;
  assign out_stat_taken = stat_taken_q;
`endif
endmodule

// File: tb/tb_alu_unit.sv
// Directed plus randomized checks of alu_unit against a queue-based reference model.
`timescale 1ns/1ps
module tb_alu_unit;
  import alu_unit_pkg::*;

  localparam int DEPTH  = 4;
  localparam int MARGIN = 1;

  typedef struct {
    ROB_POS_TYPE rob;
    logic [31:0] value;
    logic        jump;
    logic [31:0] target;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rdy   = 1'b1;
  always #5 clk = ~clk;

  alu_unit_if bus();
`ifdef ALU_STATS_EN
  logic [31:0] stat_exec, stat_taken;
`endif

  alu_unit #(.FIFO_DEPTH(DEPTH), .STALL_MARGIN(MARGIN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .bus   (bus)
`ifdef ALU_STATS_EN
    , .out_stat_exec (stat_exec)
    , .out_stat_taken(stat_taken)
`endif
  );

  int          errors = 0;
  int          checks = 0;
  exp_t        q[$];
  bit          m_stall, m_err;
  int unsigned m_exec, m_taken;

  function automatic exp_t ref_exec(OPENUM_TYPE op, logic [31:0] a, logic [31:0] b2,
                                    logic [31:0] imm, logic [31:0] pc, ROB_POS_TYPE rob);
    exp_t r;
    logic [31:0] b;
    longint sa, sb, ua, ub, p, qt;
    bit cond;
    b  = (op inside {OPENUM_ADDI, OPENUM_SLTI, OPENUM_SLTIU, OPENUM_XORI, OPENUM_ORI,
                     OPENUM_ANDI, OPENUM_SLLI, OPENUM_SRLI, OPENUM_SRAI}) ? imm : b2;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    p  = 1;
    repeat (int'(ub % 32)) p = p * 2;
    r.rob = rob; r.value = 0; r.jump = 0; r.target = 32'(ua * 0 + longint'(pc) + 4);
    cond = 0;
    case (op)
      OPENUM_ADD, OPENUM_ADDI:   r.value = 32'(ua + ub);
      OPENUM_SUB:                r.value = 32'(ua - ub);
      OPENUM_SLL, OPENUM_SLLI:   r.value = 32'(ua * p);
      OPENUM_SRL, OPENUM_SRLI:   r.value = 32'(ua / p);
      OPENUM_SRA, OPENUM_SRAI: begin
        qt = sa / p;
        if (sa < 0 && sa % p != 0) qt = qt - 1;
        r.value = 32'(qt);
      end
      OPENUM_SLT, OPENUM_SLTI:   r.value = (sa < sb) ? 1 : 0;
      OPENUM_SLTU, OPENUM_SLTIU: r.value = (ua < ub) ? 1 : 0;
      OPENUM_XOR, OPENUM_XORI:   r.value = a ^ b;
      OPENUM_OR, OPENUM_ORI:     r.value = a | b;
      OPENUM_AND, OPENUM_ANDI:   r.value = a & b;
      OPENUM_LUI:                r.value = imm;
      OPENUM_AUIPC:              r.value = 32'(longint'(pc) + longint'(imm));
      OPENUM_JAL:  begin r.value = 32'(longint'(pc) + 4); r.jump = 1;
                         r.target = 32'(longint'(pc) + longint'(imm)); end
      OPENUM_JALR: begin r.value = 32'(longint'(pc) + 4); r.jump = 1;
                         r.target = 32'(ua + longint'(imm)) & 32'hFFFF_FFFE; end
      default: ;
    endcase
    case (op)
      OPENUM_BEQ:  cond = ua == ub;
      OPENUM_BNE:  cond = ua != ub;
      OPENUM_BLT:  cond = sa <  sb;
      OPENUM_BGE:  cond = sa >= sb;
      OPENUM_BLTU: cond = ua <  ub;
      OPENUM_BGEU: cond = ua >= ub;
      default:     cond = 0;
    endcase
    if (cond) begin
      r.jump   = 1;
      r.target = 32'(longint'(pc) + longint'(imm));
    end
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    m_stall = 0; m_err = 0; m_exec = 0; m_taken = 0;
  endtask

  task automatic model_edge();
    bit   do_pop;
    exp_t r;
    if (bus.in_rob_xbp) begin
      q.delete();
    end else begin
      do_pop = (q.size() > 0) && bus.in_cdb_grant;
      if (do_pop) void'(q.pop_front());
      if (bus.in_rs_op != OPENUM_NOP) begin
        if (q.size() < DEPTH) begin
          r = ref_exec(bus.in_rs_op, bus.in_rs_value1, bus.in_rs_value2, bus.in_rs_imm,
                       bus.in_rs_pc, bus.in_rs_rob_pos);
          q.push_back(r);
          m_exec++;
          if (r.jump) m_taken++;
        end else begin
          m_err = 1;
        end
      end
    end
    m_stall = q.size() >= DEPTH - MARGIN;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rdy && rst_n) model_edge();
    #1;
  endtask

  task automatic drive(OPENUM_TYPE op, logic [31:0] v1, logic [31:0] v2, logic [31:0] imm,
                       ROB_POS_TYPE rob, logic [31:0] pc);
    bus.in_rs_op = op; bus.in_rs_value1 = v1; bus.in_rs_value2 = v2;
    bus.in_rs_imm = imm; bus.in_rs_rob_pos = rob; bus.in_rs_pc = pc;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(string tag);
    exp_t h;
    h = (q.size() > 0) ? q[0] : '{rob: ZERO_ROB, value: 0, jump: 0, target: 0};
    chk({tag, ".rob"},    32'(bus.out_cdb_rob_pos), 32'(h.rob));
    chk({tag, ".value"},  bus.out_cdb_value,        h.value);
    chk({tag, ".jump"},   32'(bus.out_cdb_jump),    32'(h.jump));
    chk({tag, ".target"}, bus.out_cdb_target,       h.target);
    chk({tag, ".stall"},  32'(bus.out_rs_stall),    32'(m_stall));
    chk({tag, ".err"},    32'(bus.out_err_overflow), 32'(m_err));
`ifdef ALU_STATS_EN
    chk({tag, ".exec"},   stat_exec,  m_exec);
    chk({tag, ".taken"},  stat_taken, m_taken);
`endif
  endtask

  initial begin
    model_reset();
    drive(OPENUM_NOP, 0, 0, 0, ZERO_ROB, 0);
    bus.in_rob_xbp = 0; bus.in_cdb_grant = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_model("reset");
    @(negedge clk); rst_n = 1;
    tick();

    // 1: ADD wraps, then CDB empties after grant
    bus.in_cdb_grant = 1;
    drive(OPENUM_ADD, 32'hFFFF_FFFF, 32'd2, 32'd0, 4'd3, 32'd0);
    tick();
    chk("t1.rob", 32'(bus.out_cdb_rob_pos), 32'd3);
    chk("t1.val", bus.out_cdb_value, 32'h1);
    chk_model("t1");
    drive(OPENUM_NOP, 0, 0, 0, ZERO_ROB, 0);
    tick();
    chk("t1.empty", 32'(bus.out_cdb_rob_pos), 32'(ZERO_ROB));

    // 2: signed vs unsigned branch
    drive(OPENUM_BLT, 32'hFFFF_FFFE, 32'd1, 32'h20, 4'd5, 32'h100);
    tick();
    chk("t2.blt_jump", 32'(bus.out_cdb_jump), 32'd1);
    chk("t2.blt_tgt", bus.out_cdb_target, 32'h120);
    chk("t2.blt_val", bus.out_cdb_value, 32'h0);
    drive(OPENUM_BLTU, 32'hFFFF_FFFE, 32'd1, 32'h20, 4'd6, 32'h100);
    tick();
    chk("t2.bltu_jump", 32'(bus.out_cdb_jump), 32'd0);
    chk("t2.bltu_tgt", bus.out_cdb_target, 32'h104);

    // 3: JALR clears bit 0 of the target
    drive(OPENUM_JALR, 32'h1003, 32'd0, 32'd4, 4'd7, 32'h40);
    tick();
    chk("t3.val", bus.out_cdb_value, 32'h44);
    chk("t3.tgt", bus.out_cdb_target, 32'h1006);
    chk("t3.jump", 32'(bus.out_cdb_jump), 32'd1);
    drive(OPENUM_NOP, 0, 0, 0, ZERO_ROB, 0);
    tick();
    chk_model("t3.drain");

    // 4: fill, stall, overflow, in-order drain
    bus.in_cdb_grant = 0;
    for (int i = 1; i <= 4; i++) begin
      drive(OPENUM_ADDI, 32'(i), 0, 32'd10, ROB_POS_TYPE'(i), 32'h200);
      tick();
      chk("t4.stall", 32'(bus.out_rs_stall), (i >= 3) ? 32'd1 : 32'd0);
    end
    drive(OPENUM_ADDI, 32'd5, 0, 32'd10, 4'd5, 32'h200);
    tick();
    chk("t4.err", 32'(bus.out_err_overflow), 32'd1);
    chk_model("t4.full");
    bus.in_cdb_grant = 1;
    drive(OPENUM_NOP, 0, 0, 0, ZERO_ROB, 0);
    for (int i = 1; i <= 4; i++) begin
      chk("t4.order", 32'(bus.out_cdb_rob_pos), 32'(i));
      tick();
    end
    chk_model("t4.drained");

    // 5: flush drops queued results and the concurrent issue
    bus.in_cdb_grant = 0;
    drive(OPENUM_ADD, 1, 2, 0, 4'd6, 0); tick();
    drive(OPENUM_ADD, 3, 4, 0, 4'd7, 0); tick();
    drive(OPENUM_ADD, 5, 6, 0, 4'd8, 0);
    bus.in_rob_xbp = 1;
    tick();
    bus.in_rob_xbp = 0;
    drive(OPENUM_NOP, 0, 0, 0, ZERO_ROB, 0);
    chk("t5.rob", 32'(bus.out_cdb_rob_pos), 32'(ZERO_ROB));
    chk("t5.stall", 32'(bus.out_rs_stall), 32'd0);
    bus.in_cdb_grant = 1;
    tick();
    chk("t5.dropped", 32'(bus.out_cdb_rob_pos), 32'(ZERO_ROB));
    chk("t5.err_sticky", 32'(bus.out_err_overflow), 32'd1);

    // 6: asynchronous reset between edges
    bus.in_cdb_grant = 0;
    for (int i = 9; i <= 11; i++) begin
      drive(OPENUM_ADD, 32'(i), 1, 0, ROB_POS_TYPE'(i), 0);
      tick();
    end
    drive(OPENUM_NOP, 0, 0, 0, ZERO_ROB, 0);
    chk_model("t6.pre");
    #3 rst_n = 0;
    model_reset();
    #1;
    chk("t6.rob", 32'(bus.out_cdb_rob_pos), 32'(ZERO_ROB));
    chk("t6.stall", 32'(bus.out_rs_stall), 32'd0);
    chk("t6.err", 32'(bus.out_err_overflow), 32'd0);
    chk_model("t6.rst");
    #2 rst_n = 1;
    tick();
    chk_model("t6.after");

    // randomized traffic with grant gaps, flushes and rdy holds
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, b;
      a = $urandom();
      b = ($urandom_range(0, 3) == 0) ? a : $urandom();
      rdy              = $urandom_range(0, 9) != 0;
      bus.in_rob_xbp   = $urandom_range(0, 24) == 0;
      bus.in_cdb_grant = $urandom_range(0, 2) != 0;
      drive(OPENUM_TYPE'(6'($urandom_range(0, int'(OPENUM_AND)))), a, b, $urandom(),
            ROB_POS_TYPE'($urandom_range(1, 15)), $urandom());
      tick();
      chk_model("rand");
    end
    rdy = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
